digit_scan_driver: RTL and testbench
====================================

DIGIT_SCAN_DRIVER -- requirements
Module: digit_scan_driver

Interface
REQ-001 SHALL have parameter PRESCALE, default 1024: clock cycles per digit slot, legal range 1 to 65535.
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have port data_in, input, 32 bits: eight hex nibbles; nibble k drives digit k, digit 0 rightmost.
REQ-005 SHALL have port dp_in, input, 8 bits: decimal-point request, one bit per digit.
REQ-006 SHALL have port in_valid, input, 1 bit: producer offers data_in/dp_in.
REQ-007 SHALL have port in_ready, output, 1 bit: block can accept an offer.
REQ-008 SHALL have port blank_lz, input, 1 bit: leading-zero blanking enable.
REQ-009 SHALL have port seg, output, 8 bits, active-low: seg[6:0] = segments g..a, seg[7] = dp.
REQ-010 SHALL have port an, output, 8 bits, active-low: one-hot digit enable.
REQ-011 SHALL have port frame_done, output, 1 bit: one-cycle pulse per completed 8-digit frame.

Function
REQ-012 SHALL run a prescaler counting 0 to PRESCALE-1 and wrapping to 0; tick is asserted in the cycle the count equals PRESCALE-1; with PRESCALE=1, tick is asserted every cycle.
REQ-013 SHALL hold a 3-bit digit index idx that increments on tick and wraps from 7 to 0.
REQ-014 SHALL hold a pending buffer (32-bit data, 8-bit dp, full flag); in_ready SHALL be the combinational inverse of the full flag.
REQ-015 SHALL accept an offer on in_valid and in_ready in the same cycle: capture data_in and dp_in into the pending buffer and set full; in_valid without in_ready SHALL be ignored and produce no state change.
REQ-016 At a frame boundary (tick with idx==7), if full was set at the start of that cycle, SHALL copy the pending buffer into the active registers and clear full in the same edge.
REQ-017 An offer accepted in the same cycle as a frame boundary with full=0 SHALL stay pending until the next boundary; the display is never updated mid-frame.
REQ-018 SHALL assert frame_done for exactly one cycle, in the cycle after each frame boundary, whether or not a transfer occurred.
REQ-019 SHALL register an and seg; both reflect idx and active registers with one cycle of latency and change in the same cycle.
REQ-020 an SHALL drive bit idx low and all other bits high.
REQ-021 SHALL decode active nibble idx with these active-high gfedcba codes, inverted onto seg[6:0]: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-022 seg[7] SHALL be the inverse of active dp bit idx.
REQ-023 When blank_lz=1, digit k (k from 1 to 7) SHALL be blanked (seg=8'hFF, dp included) if active nibbles k..7 are all zero; digit 0 SHALL never be blanked, so an all-zero value displays "0".
REQ-024 blank_lz SHALL be sampled live every cycle; it is not latched per frame.

Reset
REQ-025 While rst=1, prescaler=0, idx=0, active data=0, active dp=0, full=0, an=8'hFF, seg=8'hFF, frame_done=0; in_ready SHALL read 1.
REQ-026 A reset asserted mid-frame or with the pending buffer full SHALL discard pending data; rst takes priority over an offer or frame boundary in the same cycle.
REQ-027 In the first cycle after rst deasserts, the prescaler SHALL start from 0, and the first an update SHALL select digit 0 (an=8'hFE, seg showing "0").

Verification (PRESCALE=4)
REQ-028 Reset, then idle for 40 cycles -> an steps FE,FD,FB,...,7F every 4 cycles; seg=C0 throughout; frame_done pulses every 32 cycles.
REQ-029 Offer 32'h1234ABCD with dp_in=8'h01 mid-frame -> in_ready drops next cycle; display is unchanged until the boundary; next frame shows digit0 seg=0x21 (d with dp) and digit7 seg=0xF9 ("1"); in_ready returns to 1 at the transfer.
REQ-030 Second offer while full -> ignored, in_valid held; accepted only in the cycle after the transfer; shown one frame later.
REQ-031 Offer with full=0 in the exact boundary cycle -> not shown in the upcoming frame; shown in the frame after.
REQ-032 blank_lz=1 with data 32'h00000305 -> digits 3..7 seg=FF; digit2 shows "3"; digit1 shows "0" (0xC0); digit0 shows "5".
REQ-033 Assert rst with full=1 at idx=5 -> next cycle an=FF, seg=FF, in_ready=1; pending data is never displayed.

Source files
------------

// File: rtl/digit_scan_driver.sv
// rtl/digit_scan_driver.sv - multiplexed eight-digit seven-segment scan driver with frame-synchronous update
//
// Ports:
//   clock       rising-edge clock for all state
//   rst         synchronous active-high reset
//   data_in     eight hex nibbles offered by the producer, nibble k -> digit k (digit 0 rightmost)
//   dp_in       decimal-point request per digit
//   in_valid    producer offers data_in/dp_in
//   in_ready    pending buffer is empty and can take an offer
//   blank_lz    leading-zero blanking enable, sampled live
//   seg         active-low segments, seg[6:0] = g..a, seg[7] = dp
//   an          active-low one-hot digit enable
//   frame_done  one-cycle pulse after every completed eight-digit frame
`timescale 1ns/1ps

module digit_scan_driver #(
    parameter int PRESCALE = 1024
) (
    input  logic        clock,
    input  logic        rst,
    input  logic [31:0] data_in,
    input  logic [7:0]  dp_in,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        blank_lz,
    output logic [7:0]  seg,
    output logic [7:0]  an,
    output logic        frame_done
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] count;
    logic [2:0]    idx;
    logic [31:0]   pend_data;
    logic [7:0]    pend_dp;
    logic          full;
    logic [31:0]   act_data;
    logic [7:0]    act_dp;

    logic          tick;
    logic          boundary;
    logic          accept;
    logic [31:0]   shifted;
    logic          blank;
    logic [7:0]    seg_next;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        case (v)
            4'h0:    hex_to_seg = 7'h3F;
            4'h1:    hex_to_seg = 7'h06;
            4'h2:    hex_to_seg = 7'h5B;
            4'h3:    hex_to_seg = 7'h4F;
            4'h4:    hex_to_seg = 7'h66;
            4'h5:    hex_to_seg = 7'h6D;
            4'h6:    hex_to_seg = 7'h7D;
            4'h7:    hex_to_seg = 7'h07;
            4'h8:    hex_to_seg = 7'h7F;
            4'h9:    hex_to_seg = 7'h6F;
            4'hA:    hex_to_seg = 7'h77;
            4'hB:    hex_to_seg = 7'h7C;
            4'hC:    hex_to_seg = 7'h39;
            4'hD:    hex_to_seg = 7'h5E;
            4'hE:    hex_to_seg = 7'h79;
            default: hex_to_seg = 7'h71;
        endcase
    endfunction

    assign tick     = (count == LAST);
    assign boundary = tick && (idx == 3'd7);
    assign in_ready = ~full;
    assign accept   = in_valid && ~full;

    // Nibbles idx..7 shifted down: a zero result means this digit is a leading zero.
    assign shifted  = act_data >> {idx, 2'b00};
    assign blank    = blank_lz && (idx != 3'd0) && (shifted == 32'd0);
    assign seg_next = blank ? 8'hFF : {~act_dp[idx], ~hex_to_seg(shifted[3:0])};

    always_ff @(posedge clock) begin
        if (rst) begin
            count      <= '0;
            idx        <= 3'd0;
            pend_data  <= 32'd0;
            pend_dp    <= 8'd0;
            full       <= 1'b0;
            act_data   <= 32'd0;
            act_dp     <= 8'd0;
            an         <= 8'hFF;
            seg        <= 8'hFF;
            frame_done <= 1'b0;
        end else begin
            count      <= tick ? '0 : count + 1'b1;
            if (tick) begin
                idx <= idx + 3'd1;
            end
            // A full buffer drains at the boundary; an empty one may fill in the
            // same cycle but then waits for the following boundary.
            if (boundary && full) begin
                act_data <= pend_data;
                act_dp   <= pend_dp;
                full     <= 1'b0;
            end else if (accept) begin
                pend_data <= data_in;
                pend_dp   <= dp_in;
                full      <= 1'b1;
            end
            an         <= ~(8'd1 << idx);
            seg        <= seg_next;
            frame_done <= boundary;
        end
    end

endmodule

// File: tb/tb_digit_scan_driver.sv
// tb/tb_digit_scan_driver.sv - randomized and directed bench for digit_scan_driver against a cycle-count model
`timescale 1ns/1ps

module tb_digit_scan_driver;

    localparam int P = 4;

    logic        clock = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] data_in = 32'd0;
    logic [7:0]  dp_in = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        blank_lz = 1'b0;
    logic [7:0]  seg;
    logic [7:0]  an;
    logic        frame_done;

    digit_scan_driver #(.PRESCALE(P)) dut (
        .clock      (clock),
        .rst        (rst),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .blank_lz   (blank_lz),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: position in the scan follows from cycles elapsed since reset release.
    int          m_t = 0;
    logic        m_full = 1'b0;
    logic [31:0] m_pd = 32'd0;
    logic [7:0]  m_pdp = 8'd0;
    logic [31:0] m_act = 32'd0;
    logic [7:0]  m_adp = 8'd0;
    logic        synced = 1'b0;
    logic        last_acc = 1'b0;

    logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    function automatic logic [7:0] model_seg(input logic [31:0] d, input logic [7:0] dp,
                                             input int k, input logic bl);
        logic [31:0] upper;
        logic [3:0]  nib;
        upper = d >> (4 * k);
        nib   = upper[3:0];
        if (bl && k != 0 && upper == 32'd0) return 8'hFF;
        return {~dp[k], ~hex_tab[nib]};
    endfunction

    task automatic step();
        logic [7:0] e_an;
        logic [7:0] e_seg;
        logic       e_fd;
        logic       bnd;
        logic       acc;
        int         k;
        if (synced) chk("in_ready", in_ready, !m_full);
        k   = (m_t / P) % 8;
        bnd = (m_t % (8 * P)) == (8 * P - 1);
        acc = in_valid && !m_full;
        if (rst) begin
            e_an = 8'hFF; e_seg = 8'hFF; e_fd = 1'b0;
        end else begin
            e_an  = ~(8'd1 << k);
            e_seg = model_seg(m_act, m_adp, k, blank_lz);
            e_fd  = bnd;
        end
        @(posedge clock);
        #1;
        if (synced || rst) begin
            chk("an", an, e_an);
            chk("seg", seg, e_seg);
            chk("frame_done", frame_done, e_fd);
        end
        if (rst) begin
            m_t = 0; m_full = 0; m_pd = 0; m_pdp = 0; m_act = 0; m_adp = 0;
            synced = 1'b1;
            last_acc = 1'b0;
        end else begin
            if (bnd && m_full) begin
                m_act = m_pd; m_adp = m_pdp; m_full = 1'b0;
            end else if (acc) begin
                m_pd = data_in; m_pdp = dp_in; m_full = 1'b1;
            end
            last_acc = acc;
            m_t++;
        end
    endtask

    task automatic step_until_fd();
        int n = 0;
        while (frame_done !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        if (frame_done !== 1'b1) chk("fd_timeout", 32'd0, 32'd1);
    endtask

    task automatic step_until_an(input logic [7:0] target);
        int n = 0;
        while (an !== target && n < 100) begin
            step();
            n++;
        end
        if (an !== target) chk("an_timeout", {24'd0, an}, {24'd0, target});
    endtask

    initial begin
        int fd_cnt;
        int bad_c0;
        int n;
        logic prev_fd;

        // Pin the model itself against hand-computed codes.
        chk("model_d_dp", model_seg(32'h1234ABCD, 8'h01, 0, 1'b0), 8'h21);
        chk("model_1", model_seg(32'h1234ABCD, 8'h01, 7, 1'b0), 8'hF9);
        chk("model_blank", model_seg(32'h00000305, 8'h00, 3, 1'b1), 8'hFF);
        chk("model_zero_d0", model_seg(32'h00000000, 8'h00, 0, 1'b1), 8'hC0);

        // Reset
        rst = 1'b1;
        repeat (3) step();
        chk("rst_an", an, 8'hFF);
        chk("rst_seg", seg, 8'hFF);
        chk("rst_ready", in_ready, 1'b1);
        rst = 1'b0;

        // Idle scan
        fd_cnt = 0;
        bad_c0 = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (i == 0)  chk("idle_an0", an, 8'hFE);
            if (i == 4)  chk("idle_an1", an, 8'hFD);
            if (i == 28) chk("idle_an7", an, 8'h7F);
            if (i == 31) chk("idle_fd31", frame_done, 1'b1);
            if (frame_done) fd_cnt++;
            if (seg !== 8'hC0) bad_c0++;
        end
        chk("idle_fd_count", fd_cnt, 1);
        chk("idle_seg_c0", bad_c0, 0);

        // Mid-frame offer
        data_in = 32'h1234ABCD; dp_in = 8'h01; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("offer_ready_low", in_ready, 1'b0);
        step_until_fd();
        chk("xfer_ready_high", in_ready, 1'b1);
        step();
        chk("new_d0_an", an, 8'hFE);
        chk("new_d0_seg", seg, 8'h21);
        step_until_an(8'h7F);
        chk("new_d7_seg", seg, 8'hF9);

        // Second offer while full, held until accepted
        data_in = 32'h89ABCDEF; dp_in = 8'h00; in_valid = 1'b1;
        step();
        data_in = 32'h00000305;
        n = 0;
        prev_fd = 1'b0;
        do begin
            prev_fd = frame_done;
            step();
            n++;
        end while (!last_acc && n < 100);
        in_valid = 1'b0;
        chk("second_accepted", last_acc, 1'b1);
        chk("second_after_xfer", prev_fd, 1'b1);

        // Leading-zero blanking of 0x305 one frame later
        blank_lz = 1'b1;
        step_until_fd();
        for (int i = 0; i < 8 * P; i++) begin
            step();
            if (an == 8'hFE) chk("blank_d0", seg, 8'h92);
            if (an == 8'hFD) chk("blank_d1", seg, 8'hC0);
            if (an == 8'hFB) chk("blank_d2", seg, 8'hB0);
            if (an == 8'h7F) chk("blank_d7", seg, 8'hFF);
        end

        // Offer exactly in the boundary cycle with the buffer empty
        while ((m_t % (8 * P)) != (8 * P - 1)) step();
        data_in = 32'h00000007; dp_in = 8'h00; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("bnd_old_d0", seg, 8'h92);
        step_until_fd();
        step();
        chk("bnd_new_d0", seg, 8'hF8);

        // Reset with a full buffer at idx 5
        blank_lz = 1'b0;
        data_in = 32'hDEADBEEF; dp_in = 8'hFF; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        while (((m_t / P) % 8) != 5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_an", an, 8'hFF);
        chk("mid_rst_seg", seg, 8'hFF);
        chk("mid_rst_ready", in_ready, 1'b1);
        bad_c0 = 0;
        for (int i = 0; i < 80; i++) begin
            step();
            if (seg !== 8'hC0) bad_c0++;
        end
        chk("pending_discarded", bad_c0, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 399) == 0);
            in_valid = ($urandom_range(0, 11) == 0);
            data_in  = $urandom >> (4 * $urandom_range(0, 7));
            dp_in    = 8'($urandom);
            if ($urandom_range(0, 47) == 0) blank_lz = ~blank_lz;
            step();
        end
        rst = 1'b0;
        in_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
